// File: rtl/hex_segment_reader_if.sv
// rtl/hex_segment_reader_if.sv - segment bus inputs and decoded-snapshot valid/ready port
interface hex_segment_reader_if;
    logic [7:0]  hex0;
    logic [7:0]  hex1;
    logic [7:0]  hex2;
    logic [7:0]  hex3;
    logic [7:0]  hex4;
    logic [7:0]  hex5;
    logic [23:0] value;
    logic [5:0]  blank;
    logic [5:0]  err;
    logic [5:0]  dp;
    logic        value_valid;
    logic        value_ready;

    modport master (
        input  hex0, hex1, hex2, hex3, hex4, hex5, value_ready,
        output value, blank, err, dp, value_valid
    );

    modport slave (
        output hex0, hex1, hex2, hex3, hex4, hex5, value_ready,
        input  value, blank, err, dp, value_valid
    );
endinterface

// File: rtl/hex_segment_reader.sv
// rtl/hex_segment_reader.sv - debounced seven-segment glyph decoder with valid/ready snapshot
// Optional decimal-point capture: define HEX_DP_EN.
module hex_segment_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hex_segment_reader_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]       hex_raw [6];
    logic [7:0]       hex_in  [6];
    logic [7:0]       samp_q  [6];
    logic [7:0]       samp_d  [6];
    logic [CNT_W-1:0] cnt_q   [6];
    logic [CNT_W-1:0] cnt_d   [6];

    logic [23:0] nib_q, nib_d, snap_nib_q, snap_nib_d;
    logic [5:0]  blank_q, blank_d, snap_blank_q, snap_blank_d;
    logic [5:0]  err_q, err_d, snap_err_q, snap_err_d;
    logic [5:0]  dp_q, dp_d, snap_dp_q, snap_dp_d;
    logic        valid_q, valid_d, pending_q, pending_d;
    logic        changed;
    logic [5:0]  dec;
    logic        dp_new;

    assign hex_raw[0] = bus.hex0;
    assign hex_raw[1] = bus.hex1;
    assign hex_raw[2] = bus.hex2;
    assign hex_raw[3] = bus.hex3;
    assign hex_raw[4] = bus.hex4;
    assign hex_raw[5] = bus.hex5;

`ifndef HEX_DP_EN
    logic unused_dp;
    assign unused_dp = ^{hex_raw[0][7], hex_raw[1][7], hex_raw[2][7],
                         hex_raw[3][7], hex_raw[4][7], hex_raw[5][7]};
`endif

    // Returns {err, blank, nibble}
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = 6'h00;
            7'h79:   decode = 6'h01;
            7'h24:   decode = 6'h02;
            7'h30:   decode = 6'h03;
            7'h19:   decode = 6'h04;
            7'h12:   decode = 6'h05;
            7'h02:   decode = 6'h06;
            7'h78:   decode = 6'h07;
            7'h00:   decode = 6'h08;
            7'h10:   decode = 6'h09;
            7'h08:   decode = 6'h0A;
            7'h03:   decode = 6'h0B;
            7'h46:   decode = 6'h0C;
            7'h21:   decode = 6'h0D;
            7'h06:   decode = 6'h0E;
            7'h0E:   decode = 6'h0F;
            7'h7F:   decode = 6'h10;
            default: decode = 6'h20;
        endcase
    endfunction

    always_comb begin
        nib_d        = nib_q;
        blank_d      = blank_q;
        err_d        = err_q;
        dp_d         = dp_q;
        snap_nib_d   = snap_nib_q;
        snap_blank_d = snap_blank_q;
        snap_err_d   = snap_err_q;
        snap_dp_d    = snap_dp_q;
        valid_d      = valid_q;
        pending_d    = pending_q;
        changed      = 1'b0;
        dec          = 6'h0;
        dp_new       = 1'b0;
        for (int i = 0; i < 6; i++) begin
`ifdef HEX_DP_EN
            hex_in[i] = hex_raw[i];
`else
            hex_in[i] = {1'b1, hex_raw[i][6:0]};
`endif
            samp_d[i] = hex_in[i];
            cnt_d[i]  = '0;
            if (hex_in[i] == samp_q[i]) begin
                cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
                if (cnt_q[i] == CNT_COMMIT) begin
                    dec = decode(samp_q[i][6:0]);
`ifdef HEX_DP_EN
                    dp_new = ~samp_q[i][7];
`else
                    dp_new = 1'b0;
`endif
                    if (dec[3:0] != nib_q[4*i +: 4] || dec[4] != blank_q[i] ||
                        dec[5] != err_q[i] || dp_new != dp_q[i])
                        changed = 1'b1;
                    nib_d[4*i +: 4] = dec[3:0];
                    blank_d[i]      = dec[4];
                    err_d[i]        = dec[5];
                    dp_d[i]         = dp_new;
                end
            end
        end

        // Snapshot only reloads when empty or on a handshake; changes seen while held are remembered
        if (!valid_q) begin
            if (changed) begin
                valid_d      = 1'b1;
                snap_nib_d   = nib_d;
                snap_blank_d = blank_d;
                snap_err_d   = err_d;
                snap_dp_d    = dp_d;
            end
        end else if (bus.value_ready) begin
            if (pending_q || changed) begin
                snap_nib_d   = nib_d;
                snap_blank_d = blank_d;
                snap_err_d   = err_d;
                snap_dp_d    = dp_d;
                pending_d    = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end else if (changed) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                samp_q[i] <= 8'hFF;
                cnt_q[i]  <= '0;
            end
            nib_q        <= '0;
            blank_q      <= 6'h3F;
            err_q        <= '0;
            dp_q         <= '0;
            snap_nib_q   <= '0;
            snap_blank_q <= 6'h3F;
            snap_err_q   <= '0;
            snap_dp_q    <= '0;
            valid_q      <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                samp_q[i] <= samp_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            nib_q        <= nib_d;
            blank_q      <= blank_d;
            err_q        <= err_d;
            dp_q         <= dp_d;
            snap_nib_q   <= snap_nib_d;
            snap_blank_q <= snap_blank_d;
            snap_err_q   <= snap_err_d;
            snap_dp_q    <= snap_dp_d;
            valid_q      <= valid_d;
            pending_q    <= pending_d;
        end
    end

    assign bus.value       = snap_nib_q;
    assign bus.blank       = snap_blank_q;
    assign bus.err         = snap_err_q;
    assign bus.dp          = snap_dp_q;
    assign bus.value_valid = valid_q;
endmodule
